muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   XLEN          operand / result width (only 32 is supported)
//   F3_*          funct3 encodings of the eight M-extension operations
//   state_t       FSM state type and its three state constants
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One radix-2 step per clock: shift-add
// multiply or restoring divide on operand magnitudes, followed by a sign fixup.
// Divide-by-zero and signed overflow skip the iteration and finish on the
// accept edge.
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous, active-high reset
//   in_valid          request presented
//   out_ready         unit can accept a request (IDLE only)
//   in_funct3         operation select (MUL..REMU)
//   in_rs1_data       first operand
//   in_rs2_data       second operand
//   in_rd             destination register tag
//   in_flush          abort anything in flight, back to IDLE next edge
//   in_result_ready   writeback consumes the result
//   out_result_valid  result available (DONE only)
//   out_result        result data
//   out_rd            destination tag for the register-file write port
//   out_busy          unit is not IDLE
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            out_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rd,
    input  logic            in_flush,
    input  logic            in_result_ready,
    output logic            out_result_valid,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*XLEN-1:0]  r_acc;     // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [XLEN-1:0]    r_op2;     // multiplicand / divisor magnitude
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [XLEN-1:0]    r_result;

    // -------------------------------------------------------------------------
    // Accept-side decode: signedness, magnitudes and the two bypass cases
    // -------------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_bypass;
    logic [XLEN-1:0] w_bypass_result;

    assign w_accept   = in_valid && (r_state == ST_IDLE);

    assign w_a_signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_MULHSU) ||
                        (in_funct3 == F3_DIV)  || (in_funct3 == F3_REM);
    assign w_b_signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_DIV) ||
                        (in_funct3 == F3_REM);

    assign w_neg_a    = w_a_signed && in_rs1_data[XLEN-1];
    assign w_neg_b    = w_b_signed && in_rs2_data[XLEN-1];
    assign w_mag_a    = w_neg_a ? (~in_rs1_data + 1'b1) : in_rs1_data;
    assign w_mag_b    = w_neg_b ? (~in_rs2_data + 1'b1) : in_rs2_data;

    assign w_div_zero = in_funct3[2] && (in_rs2_data == '0);
    assign w_div_ovf  = ((in_funct3 == F3_DIV) || (in_funct3 == F3_REM)) &&
                        (in_rs1_data == MIN_NEG) && (in_rs2_data == '1);
    assign w_bypass   = w_div_zero || w_div_ovf;

    // funct3[1] separates remainder (REM/REMU) from quotient (DIV/DIVU)
    always_comb begin
        w_bypass_result = '0;
        if (w_div_zero) begin
            w_bypass_result = in_funct3[1] ? in_rs1_data : '1;
        end else begin
            w_bypass_result = in_funct3[1] ? '0 : MIN_NEG;
        end
    end

    // -------------------------------------------------------------------------
    // One iteration step on the shared 64-bit accumulator
    // -------------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_shift;
    logic              w_div_fits;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_acc_step;

    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_op2};
    // Partial remainder shifted left by one: can be XLEN+1 bits wide.
    assign w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_fits  = (w_rem_shift >= {1'b0, r_op2});
    // When it fits the true difference is below 2^XLEN, so modular subtract is exact.
    assign w_div_sub   = w_rem_shift[XLEN-1:0] - r_op2;

    always_comb begin
        w_acc_step = r_acc;
        if (!r_funct3[2]) begin
            // Shift-add: add multiplicand into the high half when the LSB of
            // the multiplier is set, then shift the whole accumulator right.
            if (r_acc[0]) begin
                w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
            end else begin
                w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end else begin
            // Restoring divide: quotient bits shift in at the bottom.
            if (w_div_fits) begin
                w_acc_step = {w_div_sub, r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sign fixup and result selection on the final step's output
    // -------------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_acc_step + 1'b1) : w_acc_step;
    assign w_quot     = w_acc_step[XLEN-1:0];
    assign w_rem      = w_acc_step[2*XLEN-1:XLEN];
    assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~w_quot + 1'b1) : w_quot;
    assign w_rem_fix  = r_neg_a ? (~w_rem + 1'b1) : w_rem;

    always_comb begin
        w_final = '0;
        case (r_funct3)
            F3_MUL:                      w_final = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             w_final = w_quot_fix;
            default:                     w_final = w_rem_fix;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_op2    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (in_flush) begin
            // Flush wins over accept and handoff; the pending result is dropped.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= in_funct3;
                        r_rd     <= in_rd;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_cnt    <= '0;
                        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
                        r_op2    <= w_mag_b;
                        if (w_bypass) begin
                            r_result <= w_bypass_result;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_result <= w_final;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_result_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_ready        = (r_state == ST_IDLE);
    assign out_busy         = (r_state != ST_IDLE);
    assign out_result_valid = (r_state == ST_DONE);
    assign out_result       = r_result;
    assign out_rd           = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Expected results come from a reference
// model built on native SystemVerilog arithmetic and are queued at request
// time, then popped when the unit presents its result.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [4:0]  in_rd = '0;
    logic        in_flush = 1'b0;
    logic        in_result_ready = 1'b0;
    logic        out_result_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_busy;

    muldiv_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .out_ready        (out_ready),
        .in_funct3        (in_funct3),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .in_rd            (in_rd),
        .in_flush         (in_flush),
        .in_result_ready  (in_result_ready),
        .out_result_valid (out_result_valid),
        .out_result       (out_result),
        .out_rd           (out_rd),
        .out_busy         (out_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    time  last_accept = 0;

    // Reference model: native signed/unsigned arithmetic, RISC-V corner cases.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        logic [31:0] r;
        ia = a;
        ib = b;
        r  = '0;
        case (f)
            F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            F3_MULH:   begin sa = ia; sb = ib; p = sa * sb; r = p[63:32]; end
            F3_MULHSU: begin sa = ia; sb = longint'({32'b0, b}); p = sa * sb; r = p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            F3_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'(ia / ib);
            end
            F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(ia % ib);
            end
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_bypass(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        return (f[2] && b == 0) ||
               ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Present one request; optionally queue its expected result.
    task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input bit expect_result);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (out_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (out_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_wait: out_ready=%b required 1", out_ready);
        end
        in_valid    = 1'b1;
        in_funct3   = f;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd       = rd;
        if (expect_result) begin
            e.res = model(f, a, b);
            e.rd  = rd;
            e.lat = is_bypass(f, a, b) ? 1 : 33;
            sb_q.push_back(e);
        end
        @(posedge clk);
        last_accept = $time;
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the result and compare it against the queue head.
    task automatic collect(input string name, output exp_t e);
        int edges;
        edges = 1;
        while (out_result_valid !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: queue empty", name);
            e.res = '0; e.rd = '0; e.lat = 0;
            return;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (out_result_valid !== 1'b1 || edges != e.lat) begin
            n_errors++;
            $display("FAIL %s latency: valid=%b after %0d edges, required %0d", name,
                     out_result_valid, edges, e.lat);
        end
        n_checks++;
        if (out_result !== e.res) begin
            n_errors++;
            $display("FAIL %s result: got %h required %h", name, out_result, e.res);
        end
        n_checks++;
        if (out_rd !== e.rd) begin
            n_errors++;
            $display("FAIL %s rd: got %0d required %0d", name, out_rd, e.rd);
        end
        n_checks++;
        if (out_ready !== 1'b0 || out_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_flags: ready=%b busy=%b required 0/1", name, out_ready, out_busy);
        end
        $display("%-14s res=%h rd=%0d lat=%0d", name, out_result, out_rd, edges);
    endtask

    // Consume the result and confirm the unit is back in IDLE.
    task automatic handoff(input string name);
        @(negedge clk);
        in_result_ready = 1'b1;
        @(posedge clk);
        #1;
        in_result_ready = 1'b0;
        n_checks++;
        if (out_ready !== 1'b1 || out_result_valid !== 1'b0 || out_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s handoff: ready=%b valid=%b busy=%b required 1/0/0", name,
                     out_ready, out_result_valid, out_busy);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        drive_req(f, a, b, rd, 1'b1);
        collect(name, e);
        handoff(name);
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_ready !== 1'b1 || out_busy !== 1'b0 || out_result_valid !== 1'b0 ||
            out_result !== 32'h0 || out_rd !== 5'h0) begin
            n_errors++;
            $display("FAIL reset_values: ready=%b busy=%b valid=%b result=%h rd=%0d required 1/0/0/0/0",
                     out_ready, out_busy, out_result_valid, out_result, out_rd);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset          applied and released");
    endtask

    task automatic test_mul();
        run_op("mul_7x-3",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1);
        run_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op("mulh_neg",     F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op("mulhsu_neg",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op("mulh_mixed",   F3_MULH,   32'h8000_0000, 32'h7FFF_FFFF, 5'd0);
    endtask

    task automatic test_div();
        run_op("div_-7/2",     F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op("rem_-7%2",     F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op("remu_7%2",     F3_REMU, 32'd7,         32'd2, 5'd5);
        run_op("div_7/-2",     F3_DIV,  32'd7,         32'hFFFF_FFFE, 5'd6);
        run_op("divu_big",     F3_DIVU, 32'hF000_0000, 32'd3, 5'd7);
    endtask

    task automatic test_bypass();
        run_op("divu_by0",     F3_DIVU, 32'd1234,      32'd0, 5'd8);
        run_op("rem_by0",      F3_REM,  32'hFFFF_FF00, 32'd0, 5'd9);
        run_op("div_ovf",      F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op("rem_ovf",      F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    endtask

    task automatic test_stall();
        exp_t e;
        drive_req(F3_DIVU, 32'd100, 32'd7, 5'd12, 1'b1);
        collect("stall_divu", e);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_result_valid !== 1'b1 || out_result !== e.res || out_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: valid=%b result=%h ready=%b required 1/%h/0",
                         i, out_result_valid, out_result, out_ready, e.res);
            end
        end
        handoff("stall_divu");
    endtask

    task automatic test_flush();
        bit saw_valid;
        drive_req(F3_MUL, 32'd1000, 32'd1000, 5'd13, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        in_flush = 1'b1;
        @(posedge clk);
        #1;
        in_flush = 1'b0;
        n_checks++;
        if (out_ready !== 1'b1 || out_busy !== 1'b0 || out_result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle: ready=%b busy=%b valid=%b required 1/0/0",
                     out_ready, out_busy, out_result_valid);
        end
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_result_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin
            n_errors++;
            $display("FAIL flush_no_result: valid seen=1 required 0");
        end
        $display("flush          busy op aborted");
        run_op("mul_3x4", F3_MUL, 32'd3, 32'd4, 5'd14);
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        drive_req(F3_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 1'b0);
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_ready !== 1'b1 || out_busy !== 1'b0 || out_result_valid !== 1'b0 ||
            out_result !== 32'h0 || out_rd !== 5'h0) begin
            n_errors++;
            $display("FAIL reset_mid: ready=%b busy=%b valid=%b result=%h rd=%0d required 1/0/0/0/0",
                     out_ready, out_busy, out_result_valid, out_result, out_rd);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_result_valid === 1'b1 || out_busy === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin
            n_errors++;
            $display("FAIL reset_mid_stale: activity seen after release, required none");
        end
        $display("reset_mid      busy op abandoned");
    endtask

    task automatic test_back_to_back();
        time prev_accept;
        bit  prev_long;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        exp_t e;
        prev_long = 1'b0;
        prev_accept = 0;
        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (f[2]) b = b | 32'd1;
            drive_req(f, a, b, 5'(i + 16), 1'b1);
            if (prev_long) begin
                n_checks++;
                if (last_accept - prev_accept < 340) begin
                    n_errors++;
                    $display("FAIL b2b_spacing[%0d]: %0t between accepts, required >= 340",
                             i, last_accept - prev_accept);
                end
            end
            prev_accept = last_accept;
            prev_long = !is_bypass(f, a, b);
            collect($sformatf("rand%0d_f%0d", i, f), e);
            handoff("b2b");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_bypass();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
